// File: rtl/uart_tx_result.sv
// UART transmit back-end: byte FIFO feeding an 8N1 serialiser (LSB first).
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_result #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flag_Tx,
  input  logic [7:0] Data_Tx,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BAUD_TC  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [CNT_W-1:0] baud;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       head;
  logic             full;
  logic             push;
  logic             pop;
  logic             baud_tc;
`ifdef UART_TX_PARITY_EN
  logic             parity;
`endif

  assign head    = mem[rd_ptr];
  assign full    = (count == FULL_CNT);
  assign baud_tc = (baud == BAUD_TC);
  // Full is judged on the pre-edge count, so a write while full is dropped
  // even when the serialiser pops on the same edge.
  assign push    = flag_Tx && !full;
  assign pop     = (count != '0) &&
                   ((state == S_IDLE) || ((state == S_STOP) && baud_tc));

  assign busy      = (state != S_IDLE) || (count != '0);
  assign fifo_full = full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= Data_Tx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (flag_Tx && full) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          baud <= '0;
          tx   <= 1'b1;
          if (pop) begin
            shift  <= head;
`ifdef UART_TX_PARITY_EN
            parity <= ^head;
`endif
            tx     <= 1'b0;
            state  <= S_START;
          end
        end

        S_START: begin
          if (baud_tc) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= S_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end

        S_DATA: begin
          if (baud_tc) begin
            baud  <= '0;
            shift <= shift >> 1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity;
              state <= S_PARITY;
`else
              tx    <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_tc) begin
            baud  <= '0;
            tx    <= 1'b1;
            state <= S_STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (baud_tc) begin
            baud <= '0;
            // A pending byte starts its start bit right away, with no idle bit.
            if (pop) begin
              shift  <= head;
`ifdef UART_TX_PARITY_EN
              parity <= ^head;
`endif
              tx     <= 1'b0;
              state  <= S_START;
            end else begin
              tx    <= 1'b1;
              state <= S_IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
          baud  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_result.md
# uart_tx_result

Transmit back-end of the matrix-by-vector accelerator. It consumes the result byte stream that `Matriz_x_Vector` emits on `flag_Tx`/`Data_Tx`, buffers it in a small FIFO, and serialises each byte onto the UART TX line as 8N1, LSB first. The block sits directly downstream of `Matriz_x_Vector` and drives the board's serial output pin.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Legal range is 2 or more.
- `FIFO_DEPTH`, default 16: number of byte entries. Must be a power of 2, 2 or more.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `flag_Tx`  in  1: single-cycle write strobe from `Matriz_x_Vector`.
- `Data_Tx`  in  8: result byte. Sampled on the edge where `flag_Tx`=1.
- `tx`  out  1: UART serial line. Registered; idles high.
- `busy`  out  1: high while the FIFO is non-empty or a frame is in flight.
- `fifo_full`  out  1: FIFO holds `FIFO_DEPTH` entries.
- `overflow`  out  1: sticky. Set when a write is dropped; cleared only by reset.

## Operation
- FIFO:
  - Circular buffer with read and write pointers (log2(`FIFO_DEPTH`) bits, wrap-around) and a count register (log2(`FIFO_DEPTH`)+1 bits).
  - Push happens when `flag_Tx`=1 and the FIFO is not full.
  - Pop happens only when the FSM loads the shift register.
- Write while full:
  - The byte is dropped and `overflow` is set, even if a pop occurs on the same edge. Full is evaluated before the pop.
- Simultaneous push and pop when not full: the count is unchanged and both pointers advance.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - The baud counter counts 0..`CLKS_PER_BIT`-1 in every non-IDLE state. The state advances when the counter reaches terminal count.
  - IDLE: if the FIFO is non-empty, pop, load the shift register, `tx`<=0, go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA. The bit index is set to 0.
  - DATA: `tx`=shift[0]. At terminal count, shift right and increment the index. After index 7, go to PARITY if compiled in, otherwise to STOP.
  - PARITY: `tx`= XOR of the 8 data bits (even parity). Lasts `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. At terminal count:
    - if the FIFO is non-empty, pop and go directly to START with no idle bit;
    - otherwise go to IDLE.
- `busy` = (state != IDLE) OR (count != 0). It is registered-equivalent: derived from registers only.
- `fifo_full` = (count == `FIFO_DEPTH`).
- Reset, asynchronous, at any time including mid-frame:
  - `tx`=1, `busy`=0, `fifo_full`=0, `overflow`=0.
  - FSM returns to IDLE; pointers, count and baud counter are cleared.
  - The FIFO contents are discarded and no partial frame resumes.

## Timing
- Write-to-line latency: a byte written at edge k into an empty FIFO with the FSM idle drives `tx` low from edge k+1.
- Frame length: 10×`CLKS_PER_BIT` cycles, or 11×`CLKS_PER_BIT` with parity.
- Back-to-back frames: the start bit of the next byte begins on the edge immediately after the last stop-bit cycle.
- `flag_Tx` may assert on consecutive cycles. Every cycle with `flag_Tx`=1 is a distinct write.
- Outputs change only on `clk` rising edges, except on reset assertion.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: PARITY state compiled in; frame is 8E1, 11 bit times.
  - Undefined: PARITY state and XOR logic absent; frame is 8N1, 10 bit times. DATA goes directly to STOP.

## Test plan
Use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4 unless noted.
- Single byte: write 0xA5 at edge k.
  - `tx`=0 for cycles k+1..k+4.
  - Data bits 1,0,1,0,0,1,0,1, 4 cycles each.
  - Stop bit high, then IDLE; `busy` falls at cycle k+41.
  - `fifo_full` and `overflow` stay 0.
- Back-to-back: write 0x01, 0x02, 0x03, 0x04 on consecutive cycles.
  - Four contiguous frames totalling 160 cycles, with no high gap between a stop bit and the next start bit.
  - Bytes arrive in order.
- Overflow: write 0x10..0x15 on 6 consecutive cycles.
  - 0x10 pops at the first edge after it is written.
  - `fifo_full`=1 after 0x14 is written.
  - 0x15 is dropped and `overflow`=1, held through the later drain.
  - Exactly 5 frames are sent: 0x10..0x14.
- Reset mid-frame: write 0x3C, then assert `rst`=0 during data bit 3.
  - `tx`=1 immediately and `busy`=0.
  - After release, no frame is sent until a new write.
- Parity build (`UART_TX_PARITY_EN` defined):
  - 0x07 produces parity bit 1.
  - 0x03 produces parity bit 0.
  - Frames are 44 cycles.
- Pipeline integration: drive `Matriz_x_Vector` with a 4×4 matrix of 0x00..0x0F and vector 1,2,3,4.
  - Decoded UART bytes equal the `Data_Tx` sequence captured at `flag_Tx`, in order.
